// File: rtl/fifo_record_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// fifo_record_unpacker_pkg
// Shared readout definitions: FIFO word / record / slice widths, the header
// marker shared with the write-side packer, the pad slice, the record-select
// encoding used by the unpacker and a slice extraction helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_record_unpacker_pkg;

    localparam int FIFO_WORD_W = 36;
    localparam int REC_W       = 24;
    localparam int SLICE_W     = 12;

    // Header tag in the low slice; must match the FIFO write-side packer.
    localparam logic [SLICE_W-1:0] RO_HDR_MARKER = 12'hEC5;
    localparam logic [SLICE_W-1:0] RO_FILL_WORD  = 12'h000;

    // What the unpacker does with the output stage in a given cycle.
    typedef enum logic [2:0] {
        SEL_NONE      = 3'd0,   // nothing loaded
        SEL_HDR_PAD   = 3'd1,   // header waiting, residue padded out first
        SEL_HDR       = 3'd2,   // header record
        SEL_RES_DATA  = 3'd3,   // residue + next slice
        SEL_DATA2     = 3'd4,   // two slices of the held word
        SEL_TO_RES    = 3'd5,   // last slice parked in residue, no record
        SEL_FLUSH_PAD = 3'd6    // flush: residue padded out
    } rec_sel_e;

    // Slice idx of a data word; slice 0 is the earliest in the stream.
    function automatic logic [SLICE_W-1:0] get_slice(
        input logic [FIFO_WORD_W-1:0] word,
        input logic [1:0]             idx
    );
        logic [SLICE_W-1:0] s;
        case (idx)
            2'd0:    s = word[11:0];
            2'd1:    s = word[23:12];
            2'd2:    s = word[35:24];
            default: s = 12'h000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fifo_record_unpacker_if.sv
// -----------------------------------------------------------------------------
// fifo_record_unpacker_if
// Bus between the readout FIFO / serializer environment and the unpacker.
//   FifoOut[35:0]  FIFO read data (first-word-fall-through)
//   Empty          FIFO empty
//   rinc           FIFO pop
//   Flush          end-of-event pulse
//   RecOut[23:0]   record data
//   RecValid       record valid
//   RecIsHeader    record is a header
//   RecReady       downstream ready
//   Busy           unpacker holds pending data
// Modports: slave = unpacker, master = surrounding FIFO/serializer side.
// -----------------------------------------------------------------------------
interface fifo_record_unpacker_if;
    import fifo_record_unpacker_pkg::*;

    logic [FIFO_WORD_W-1:0] FifoOut;
    logic                   Empty;
    logic                   rinc;
    logic                   Flush;
    logic [REC_W-1:0]       RecOut;
    logic                   RecValid;
    logic                   RecIsHeader;
    logic                   RecReady;
    logic                   Busy;

    modport slave (
        input  FifoOut, Empty, Flush, RecReady,
        output rinc, RecOut, RecValid, RecIsHeader, Busy
    );

    modport master (
        output FifoOut, Empty, Flush, RecReady,
        input  rinc, RecOut, RecValid, RecIsHeader, Busy
    );

endinterface

// File: rtl/fifo_record_unpacker_rec_out_stage.sv
// -----------------------------------------------------------------------------
// rec_out_stage
// Registered 24-bit valid/ready output stage. Payload is held stable while
// rec_valid && !rec_ready; a new record may load in the same cycle the current
// one is accepted.
// Ports:
//   Clk, Reset     clock, synchronous active-low reset
//   load           load a new record (only when stage_free)
//   load_data/hdr/pad  record payload, header flag, pad flag
//   rec_ready      downstream ready
//   rec_out/rec_valid/rec_is_header/rec_is_pad  registered record
//   stage_free     stage can take a record this cycle
// -----------------------------------------------------------------------------
module rec_out_stage
    import fifo_record_unpacker_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [REC_W-1:0] load_data,
    input  logic             load_hdr,
    input  logic             load_pad,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_out,
    output logic             rec_valid,
    output logic             rec_is_header,
    output logic             rec_is_pad,
    output logic             stage_free
);

    assign stage_free = !rec_valid || rec_ready;

    // Output register: load, drop on acceptance, otherwise hold.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rec_out       <= 24'h000000;
            rec_valid     <= 1'b0;
            rec_is_header <= 1'b0;
            rec_is_pad    <= 1'b0;
        end else if (load) begin
            rec_out       <= load_data;
            rec_valid     <= 1'b1;
            rec_is_header <= load_hdr;
            rec_is_pad    <= load_pad;
        end else if (rec_valid && rec_ready) begin
            rec_valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_record_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_record_unpacker
// Read side of the 36-bit readout FIFO. Pops words and splits them into 24-bit
// records: a header word {hdr[23:0], HDR_MARKER} gives one header record, a
// data word {W2,W1,W0} is streamed W0,W1,W2 into records via a 12-bit residue.
// Flush pads out a pending residue with FILL_WORD.
// Ports:
//   Clk, Reset   clock, synchronous active-low reset
//   bus          fifo_record_unpacker_if.slave (FIFO read + record output)
//   HdrCount, PadCount [15:0]  accepted header / padded record counters,
//                present only when UNPACK_STATS_EN is defined
// Configuration macro: UNPACK_STATS_EN
// -----------------------------------------------------------------------------
module fifo_record_unpacker
    import fifo_record_unpacker_pkg::*;
#(
    parameter logic [SLICE_W-1:0] HDR_MARKER = RO_HDR_MARKER,
    parameter logic [SLICE_W-1:0] FILL_WORD  = RO_FILL_WORD
) (
    input  logic                 Clk,
    input  logic                 Reset,
    fifo_record_unpacker_if.slave bus
`ifdef UNPACK_STATS_EN
    ,
    output logic [15:0]          HdrCount,
    output logic [15:0]          PadCount
`endif
);

    // Hold register
    logic [FIFO_WORD_W-1:0] hold_word_r;
    logic                   hold_hdr_r;
    logic [1:0]             hold_nslice_r;
    logic                   hold_v_r;
    logic                   hold_post_r;    // word popped after the pending flush
    // Residue and flush
    logic [SLICE_W-1:0]     res_r;
    logic                   res_v_r;
    logic                   flush_pend_r;

    logic                   pop_s;
    logic                   is_hdr_s;
    logic                   stage_free_s;
    logic                   flush_ok_s;
    logic                   flush_drop_s;
    logic                   flush_clr_s;
    rec_sel_e               sel_s;
    logic [1:0]             idx_a_s;
    logic [SLICE_W-1:0]     slice_a_s;
    logic [SLICE_W-1:0]     slice_b_s;
    logic                   load_s;
    logic [REC_W-1:0]       load_data_s;
    logic                   load_hdr_s;
    logic                   load_pad_s;
    logic                   hold_free_s;
    logic [1:0]             nslice_nxt_s;
    logic                   res_clr_s;
    logic                   res_set_s;
    logic [REC_W-1:0]       rec_out_s;
    logic                   rec_valid_s;
    logic                   rec_hdr_s;
    logic                   rec_pad_s;

    // Gated by Reset so no pop is issued while the datapath is held in reset.
    assign pop_s    = Reset && !bus.Empty && !hold_v_r;
    assign is_hdr_s = (bus.FifoOut[11:0] == HDR_MARKER);

    // A pending flush may act once nothing older than it sits in hold.
    assign flush_ok_s   = flush_pend_r && (!hold_v_r || hold_post_r);
    assign flush_drop_s = flush_ok_s && !res_v_r;

    assign idx_a_s   = 2'd3 - hold_nslice_r;
    assign slice_a_s = get_slice(hold_word_r, idx_a_s);
    assign slice_b_s = get_slice(hold_word_r, idx_a_s + 2'd1);

    // Record selection priority when the output stage can take a record.
    always_comb begin
        sel_s = SEL_NONE;
        if (stage_free_s) begin
            if (flush_ok_s && res_v_r) begin
                sel_s = SEL_FLUSH_PAD;
            end else if (hold_v_r && hold_hdr_r) begin
                sel_s = res_v_r ? SEL_HDR_PAD : SEL_HDR;
            end else if (hold_v_r) begin
                if (res_v_r) begin
                    sel_s = SEL_RES_DATA;
                end else if (hold_nslice_r >= 2'd2) begin
                    sel_s = SEL_DATA2;
                end else begin
                    sel_s = SEL_TO_RES;
                end
            end else begin
                sel_s = SEL_NONE;
            end
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Datapath controls for the selected action.
    always_comb begin
        load_s       = 1'b0;
        load_data_s  = 24'h000000;
        load_hdr_s   = 1'b0;
        load_pad_s   = 1'b0;
        hold_free_s  = 1'b0;
        nslice_nxt_s = hold_nslice_r;
        res_clr_s    = 1'b0;
        res_set_s    = 1'b0;
        case (sel_s)
            SEL_HDR_PAD, SEL_FLUSH_PAD: begin
                load_s      = 1'b1;
                load_data_s = {res_r, FILL_WORD};
                load_pad_s  = 1'b1;
                res_clr_s   = 1'b1;
            end
            SEL_HDR: begin
                load_s      = 1'b1;
                load_data_s = hold_word_r[35:12];
                load_hdr_s  = 1'b1;
                hold_free_s = 1'b1;
            end
            SEL_RES_DATA: begin
                load_s       = 1'b1;
                load_data_s  = {res_r, slice_a_s};
                res_clr_s    = 1'b1;
                nslice_nxt_s = hold_nslice_r - 2'd1;
                hold_free_s  = (hold_nslice_r == 2'd1);
            end
            SEL_DATA2: begin
                load_s       = 1'b1;
                load_data_s  = {slice_a_s, slice_b_s};
                nslice_nxt_s = hold_nslice_r - 2'd2;
                hold_free_s  = (hold_nslice_r == 2'd2);
            end
            SEL_TO_RES: begin
                res_set_s   = 1'b1;
                hold_free_s = 1'b1;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    assign flush_clr_s = (sel_s == SEL_FLUSH_PAD) || flush_drop_s;

    // Hold register: load on pop, release when its last slice is used.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hold_word_r   <= 36'h0;
            hold_hdr_r    <= 1'b0;
            hold_nslice_r <= 2'd0;
            hold_v_r      <= 1'b0;
            hold_post_r   <= 1'b0;
        end else if (pop_s) begin
            hold_word_r   <= bus.FifoOut;
            hold_hdr_r    <= is_hdr_s;
            hold_nslice_r <= is_hdr_s ? 2'd0 : 2'd3;
            hold_v_r      <= 1'b1;
            hold_post_r   <= (flush_pend_r && !flush_clr_s) || bus.Flush;
        end else if (hold_free_s) begin
            hold_v_r      <= 1'b0;
            hold_post_r   <= 1'b0;
        end else begin
            hold_nslice_r <= nslice_nxt_s;
            if (flush_clr_s) begin
                hold_post_r <= 1'b0;
            end
        end
    end

    // Residue slice carried between data words.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            res_r   <= 12'h000;
            res_v_r <= 1'b0;
        end else if (res_clr_s) begin
            res_v_r <= 1'b0;
        end else if (res_set_s) begin
            res_r   <= slice_a_s;
            res_v_r <= 1'b1;
        end
    end

    // Flush request pending until padded out or dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            flush_pend_r <= 1'b0;
        end else begin
            flush_pend_r <= (flush_pend_r && !flush_clr_s) || bus.Flush;
        end
    end

    rec_out_stage u_rec_out_stage (
        .Clk           (Clk),
        .Reset         (Reset),
        .load          (load_s),
        .load_data     (load_data_s),
        .load_hdr      (load_hdr_s),
        .load_pad      (load_pad_s),
        .rec_ready     (bus.RecReady),
        .rec_out       (rec_out_s),
        .rec_valid     (rec_valid_s),
        .rec_is_header (rec_hdr_s),
        .rec_is_pad    (rec_pad_s),
        .stage_free    (stage_free_s)
    );

    assign bus.rinc        = pop_s;
    assign bus.RecOut      = rec_out_s;
    assign bus.RecValid    = rec_valid_s;
    assign bus.RecIsHeader = rec_hdr_s;
    assign bus.Busy        = hold_v_r | res_v_r | rec_valid_s | flush_pend_r;

`ifdef UNPACK_STATS_EN
    logic [15:0] hdr_cnt_r;
    logic [15:0] pad_cnt_r;

    // Accepted header / padded record counters, wrapping at 16'hFFFF.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hdr_cnt_r <= 16'd0;
            pad_cnt_r <= 16'd0;
        end else if (rec_valid_s && bus.RecReady) begin
            if (rec_hdr_s) begin
                hdr_cnt_r <= hdr_cnt_r + 16'd1;
            end
            if (rec_pad_s) begin
                pad_cnt_r <= pad_cnt_r + 16'd1;
            end
        end
    end

    assign HdrCount = hdr_cnt_r;
    assign PadCount = pad_cnt_r;
`else
    logic stats_unused_s;
    assign stats_unused_s = rec_pad_s;
`endif

endmodule
